ex_divider: RTL and testbench

//  Iterative radix-2 divider for RV64M DIV/DIVU/REM/REMU and DIV[U]W/REM[U]W in the EX stage.

---
 rtl/ex_divider.sv | 120 ++++++++++++
 tb/tb_ex_divider.sv | 99 +++++++++
 2 files changed

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// Divide-by-zero and signed overflow take a single-cycle fast path out of IDLE.
module ex_divider #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_div, r_res;
  logic            r_neg_q, r_neg_r, r_sel_rem, r_word;

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Operand preparation: extend word operands, then take magnitudes for signed ops.
  logic            w_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a, w_b, w_a_mag, w_b_mag, w_min;
  assign w_signed = ~op_i[0];
  assign w_a = word_i ? (w_signed ? {{HALF{src1_i[HALF-1]}}, src1_i[HALF-1:0]}
                                  : {{HALF{1'b0}}, src1_i[HALF-1:0]}) : src1_i;
  assign w_b = word_i ? (w_signed ? {{HALF{src2_i[HALF-1]}}, src2_i[HALF-1:0]}
                                  : {{HALF{1'b0}}, src2_i[HALF-1:0]}) : src2_i;
  assign w_a_neg = w_signed & w_a[XLEN-1];
  assign w_b_neg = w_signed & w_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a : w_a;
  assign w_b_mag = w_b_neg ? -w_b : w_b;
  assign w_min   = word_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

  // After extension, 64-bit compares are equivalent to the 32-bit checks for word ops.
  logic            w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_fsel, w_fres;
  assign w_div0 = (w_b == '0);
  assign w_ovf  = w_signed & (w_a == w_min) & (w_b == '1);
  assign w_fast = w_div0 | w_ovf;
  assign w_fsel = op_i[1] ? (w_div0 ? w_a : '0) : (w_div0 ? '1 : w_a);
  assign w_fres = fix_w(w_fsel, word_i);

  // One restoring step: the shifted remainder needs XLEN+1 bits before the trial subtract.
  logic [XLEN:0]   w_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub, w_rem_nxt, w_quo_nxt, w_qs, w_rs;
  assign w_sh      = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_sh >= {1'b0, r_div});
  assign w_sub     = w_sh[XLEN-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_sub : w_sh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_qs      = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rs      = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  logic w_go;
  assign w_go     = (r_state == IDLE) & valid_i & ~flush_i & ~reset;
  assign busy_o   = ~flush_i & ~reset & ((w_go & ~w_fast) | (r_state == RUN));
  assign done_o   = ~flush_i & ~reset & ((w_go & w_fast) | (r_state == DONE));
  assign result_o = !done_o ? '0 : ((r_state == DONE) ? r_res : w_fres);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_res     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_word    <= 1'b0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (valid_i && !w_fast) begin
          r_rem     <= '0;
          r_quo     <= word_i ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag;
          r_div     <= w_b_mag;
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_sel_rem <= op_i[1];
          r_word    <= word_i;
          r_cnt     <= word_i ? CW'(HALF) : CW'(XLEN);
          r_state   <= RUN;
        end
        RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_res   <= fix_w(r_sel_rem ? w_rs : w_qs, r_word);
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  a_valid_held: assert property (@(posedge clock) disable iff (reset)
    (r_state == RUN && !flush_i) |-> valid_i);

endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider: latency, fast paths, word ops, flush/reset abort.
module tb_ex_divider;
  logic        clock = 1'b0;
  logic        reset, valid_i, word_i, flush_i;
  logic [1:0]  op_i;
  logic [63:0] src1_i, src2_i;
  logic        busy_o, done_o;
  logic [63:0] result_o;

  int n_vec = 0;
  int n_err = 0;

  ex_divider #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .op_i(op_i), .word_i(word_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // abort_cyc < 0: normal run. Otherwise flush (or reset) is raised in that cycle.
  task automatic run(input string tag, input logic [1:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                     input int exp_done, input int abort_cyc, input logic abort_rst);
    int busy_n = 0;
    int done_cyc = -1;
    int late_done = 0;
    logic [63:0] res = '0;
    @(posedge clock); #1;
    op_i = op; word_i = w; src1_i = a; src2_i = b; valid_i = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == abort_cyc) begin
        if (abort_rst) reset = 1'b1; else flush_i = 1'b1;
      end
      @(negedge clock);
      if (busy_o) busy_n++;
      if (done_o && done_cyc < 0) begin done_cyc = cyc; res = result_o; end
      if (cyc == abort_cyc) begin
        chk({tag, " abort busy"}, 64'(busy_o), 64'd0);
        chk({tag, " abort done"}, 64'(done_o), 64'd0);
        break;
      end
      if (done_o) break;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    valid_i = 1'b0; flush_i = 1'b0; reset = 1'b0;
    if (abort_cyc >= 0) begin
      for (int i = 0; i < 80; i++) begin
        @(negedge clock);
        if (done_o) late_done++;
      end
      chk({tag, " no done after abort"}, 64'(late_done), 64'd0);
    end else begin
      chk({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done));
      chk({tag, " busy cycles"}, 64'(busy_n), 64'(exp_done));
      chk({tag, " result"}, res, exp);
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; word_i = 1'b0;
    op_i = 2'b00; src1_i = '0; src2_i = '0;
    #12;
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(posedge clock); #1; reset = 1'b0;

    run("DIV 100/-7",  2'b00, 1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, -1, 1'b0);
    run("REM -100%7",  2'b10, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, -1, 1'b0);
    run("REMU 100%7",  2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65, -1, 1'b0);
    run("DIVU x/0",    2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 1'b0);
    run("REM x%0",     2'b10, 1'b0, 64'h1234, 64'd0, 64'h1234, 0, -1, 1'b0);
    run("DIV ovf",     2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 0, -1, 1'b0);
    run("REM ovf",     2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'd0, 0, -1, 1'b0);
    run("DIVW -7/2",   2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 33, -1, 1'b0);
    run("DIVUW",       2'b01, 1'b1, 64'h0000_0000_8000_0000, 64'd1,
        64'hFFFF_FFFF_8000_0000, 33, -1, 1'b0);
    run("DIV flush",   2'b00, 1'b0, 64'd100, -64'sd7, 64'd0, 0, 10, 1'b0);
    run("DIVU 10/3 a", 2'b01, 1'b0, 64'd10, 64'd3, 64'd3, 65, -1, 1'b0);
    run("DIV reset",   2'b00, 1'b0, 64'd100, -64'sd7, 64'd0, 0, 10, 1'b1);
    run("DIVU 10/3 b", 2'b01, 1'b0, 64'd10, 64'd3, 64'd3, 65, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
